// File: rtl/fetch_queue.sv
// Two-wide instruction fetch queue: circular buffer between fetch and decode.
// Optional idle-cycle counter output enabled by defining FETCHQ_PERF_EN.
module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               push_cnt,
  input  logic [31:0]              InstrF1,
  input  logic [31:0]              InstrF2,
  input  logic [31:0]              PCF1,
  input  logic [31:0]              PCF2,
  input  logic                     predict_taken_F1,
  input  logic                     predict_taken_F2,
  output logic                     push_ready,
  input  logic [1:0]               pop_cnt,
  output logic [31:0]              InstrD1,
  output logic [31:0]              InstrD2,
  output logic [31:0]              PCD1,
  output logic [31:0]              PCD2,
  output logic                     predict_taken_D1,
  output logic                     predict_taken_D2,
  output logic                     validD1,
  output logic                     validD2,
`ifdef FETCHQ_PERF_EN
  output logic [31:0]              empty_cycles,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic          pt_mem    [DEPTH];

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW-1:0] wptr_p1, rptr_p1;
  logic [CW-1:0] count_q;
  logic [1:0]    push_acc, pop_req, pop_acc;

  assign count      = count_q;
  assign push_ready = (count_q <= CW'(DEPTH - 2));
  assign wptr_p1    = wptr_q + AW'(1);
  assign rptr_p1    = rptr_q + AW'(1);
  assign validD1    = (count_q >= CW'(1));
  assign validD2    = (count_q >= CW'(2));

  always_comb begin
    push_acc = 2'd0;
    if (push_ready && (push_cnt == 2'd1 || push_cnt == 2'd2)) push_acc = push_cnt;
    pop_req = (pop_cnt == 2'd3) ? 2'd0 : pop_cnt;
    // A short queue can only give up what it holds (count is 0 or 1 here).
    pop_acc = (CW'(pop_req) > count_q) ? count_q[1:0] : pop_req;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(push_acc);
      rptr_q  <= rptr_q + AW'(pop_acc);
      count_q <= count_q + CW'(push_acc) - CW'(pop_acc);
    end
  end

  // Payload storage needs no reset: outputs are masked by the valid flags.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (push_acc != 2'd0) begin
        instr_mem[wptr_q] <= InstrF1;
        pc_mem[wptr_q]    <= PCF1;
        pt_mem[wptr_q]    <= predict_taken_F1;
      end
      if (push_acc == 2'd2) begin
        instr_mem[wptr_p1] <= InstrF2;
        pc_mem[wptr_p1]    <= PCF2;
        pt_mem[wptr_p1]    <= predict_taken_F2;
      end
    end
  end

  always_comb begin
    InstrD1          = NOP;
    PCD1             = 32'd0;
    predict_taken_D1 = 1'b0;
    InstrD2          = NOP;
    PCD2             = 32'd0;
    predict_taken_D2 = 1'b0;
    if (validD1) begin
      InstrD1          = instr_mem[rptr_q];
      PCD1             = pc_mem[rptr_q];
      predict_taken_D1 = pt_mem[rptr_q];
    end
    if (validD2) begin
      InstrD2          = instr_mem[rptr_p1];
      PCD2             = pc_mem[rptr_p1];
      predict_taken_D2 = pt_mem[rptr_p1];
    end
  end

`ifdef FETCHQ_PERF_EN
  // Counts starved-decode cycles; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      empty_cycles <= 32'd0;
    end else if (!validD1) begin
      empty_cycles <= empty_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed
// literal checks; randomized push/pop/flush/reset traffic.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pt;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [1:0]    push_cnt, pop_cnt;
  logic [31:0]   InstrF1, InstrF2, PCF1, PCF2;
  logic          predict_taken_F1, predict_taken_F2;
  logic          push_ready;
  logic [31:0]   InstrD1, InstrD2, PCD1, PCD2;
  logic          predict_taken_D1, predict_taken_D2;
  logic          validD1, validD2;
  logic [CW-1:0] count;
`ifdef FETCHQ_PERF_EN
  logic [31:0]   empty_cycles;
`endif

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .push_cnt         (push_cnt),
    .InstrF1          (InstrF1),
    .InstrF2          (InstrF2),
    .PCF1             (PCF1),
    .PCF2             (PCF2),
    .predict_taken_F1 (predict_taken_F1),
    .predict_taken_F2 (predict_taken_F2),
    .push_ready       (push_ready),
    .pop_cnt          (pop_cnt),
    .InstrD1          (InstrD1),
    .InstrD2          (InstrD2),
    .PCD1             (PCD1),
    .PCD2             (PCD2),
    .predict_taken_D1 (predict_taken_D1),
    .predict_taken_D2 (predict_taken_D2),
    .validD1          (validD1),
    .validD2          (validD2),
`ifdef FETCHQ_PERF_EN
    .empty_cycles     (empty_cycles),
`endif
    .count            (count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  entry_t      q[$];
  int unsigned emp_m  = 0;
  logic [31:0] next_pc = 32'd0;
  bit          model_ok = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = q.size();
    chk("count", 64'(count), 64'(sz));
    chk("push_ready", 64'(push_ready), 64'((DEPTH - sz) >= 2));
    chk("validD1", 64'(validD1), 64'(sz >= 1));
    chk("validD2", 64'(validD2), 64'(sz >= 2));
    chk("InstrD1", 64'(InstrD1), 64'((sz >= 1) ? q[0].instr : 32'h13));
    chk("PCD1", 64'(PCD1), 64'((sz >= 1) ? q[0].pc : 32'h0));
    chk("ptD1", 64'(predict_taken_D1), 64'((sz >= 1) ? q[0].pt : 1'b0));
    chk("InstrD2", 64'(InstrD2), 64'((sz >= 2) ? q[1].instr : 32'h13));
    chk("PCD2", 64'(PCD2), 64'((sz >= 2) ? q[1].pc : 32'h0));
    chk("ptD2", 64'(predict_taken_D2), 64'((sz >= 2) ? q[1].pt : 1'b0));
`ifdef FETCHQ_PERF_EN
    chk("empty_cycles", 64'(empty_cycles), 64'(emp_m));
`endif
  endtask

  // One clock: drive, compare against model, advance model, cross the edge.
  task automatic step(input logic r, input logic f, input logic [1:0] pu, input logic [1:0] po);
    int     acc_push, acc_pop, pr;
    entry_t e;
    rst = r; flush = f; push_cnt = pu; pop_cnt = po;
    InstrF1 = $urandom; InstrF2 = $urandom;
    PCF1 = next_pc; PCF2 = next_pc + 32'd4;
    predict_taken_F1 = 1'($urandom_range(0, 1));
    predict_taken_F2 = 1'($urandom_range(0, 1));
    #1;
    if (model_ok) check_model();
    if (r) begin
      q.delete();
      emp_m    = 0;
      next_pc  = 32'd0;
      model_ok = 1'b1;
    end else begin
      if (q.size() == 0) emp_m++;
      if (f) begin
        q.delete();
      end else begin
        acc_push = ((DEPTH - q.size()) >= 2 && (pu == 2'd1 || pu == 2'd2)) ? int'(pu) : 0;
        pr       = (po == 2'd3) ? 0 : int'(po);
        acc_pop  = (pr < q.size()) ? pr : q.size();
        for (int i = 0; i < acc_pop; i++) void'(q.pop_front());
        if (acc_push >= 1) begin
          e.instr = InstrF1; e.pc = PCF1; e.pt = predict_taken_F1;
          q.push_back(e);
        end
        if (acc_push == 2) begin
          e.instr = InstrF2; e.pc = PCF2; e.pt = predict_taken_F2;
          q.push_back(e);
        end
        next_pc = next_pc + 32'(4 * acc_push);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] ec0;
    logic        r, f;
    logic [1:0]  pu, po;

    // Reset state
    step(1, 0, 0, 0);
    chk("rst count", 64'(count), 64'd0);
    chk("rst push_ready", 64'(push_ready), 64'd1);
    chk("rst validD1", 64'(validD1), 64'd0);
    chk("rst InstrD1", 64'(InstrD1), 64'h13);

    // First push visible next cycle
    step(0, 0, 2, 0);
    chk("p2 count", 64'(count), 64'd2);
    chk("p2 validD1", 64'(validD1), 64'd1);
    chk("p2 validD2", 64'(validD2), 64'd1);
    chk("p2 PCD1", 64'(PCD1), 64'h0);
    chk("p2 PCD2", 64'(PCD2), 64'h4);

    // Fill to full; push while full is ignored
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2, 0);
    chk("fill6 count", 64'(count), 64'd6);
    chk("fill6 push_ready", 64'(push_ready), 64'd1);
    step(0, 0, 2, 0);
    chk("full count", 64'(count), 64'd8);
    chk("full push_ready", 64'(push_ready), 64'd0);
    step(0, 0, 2, 0);
    chk("full ignore count", 64'(count), 64'd8);

    // Over-pop from a single entry
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 2);
    chk("overpop count", 64'(count), 64'd0);
    chk("overpop InstrD1", 64'(InstrD1), 64'h13);
    chk("overpop validD1", 64'(validD1), 64'd0);

    // Simultaneous push/pop, then wrap with strict PC order
    step(1, 0, 0, 0);
    step(0, 0, 2, 0);
    step(0, 0, 1, 0);
    step(0, 0, 2, 1);
    chk("pushpop count", 64'(count), 64'd4);
    chk("pushpop PCD1", 64'(PCD1), 64'h4);
    exp_pc = 32'h4;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 2, 2);
      exp_pc = exp_pc + 32'd8;
      chk("wrap PCD1", 64'(PCD1), 64'(exp_pc));
      chk("wrap PCD2", 64'(PCD2), 64'(exp_pc + 32'd4));
    end

    // Flush beats same-cycle push
    step(1, 0, 0, 0);
    step(0, 0, 2, 0);
    step(0, 0, 2, 0);
    step(0, 0, 1, 0);
    chk("pre-flush count", 64'(count), 64'd5);
    step(0, 1, 2, 0);
    chk("flush count", 64'(count), 64'd0);
    chk("flush validD1", 64'(validD1), 64'd0);
`ifdef FETCHQ_PERF_EN
    ec0 = empty_cycles;
    step(0, 0, 0, 0);
    chk("idle empty_cycles", 64'(empty_cycles), 64'(ec0 + 32'd1));
    step(0, 0, 0, 0);
    chk("idle2 empty_cycles", 64'(empty_cycles), 64'(ec0 + 32'd2));
`else
    ec0 = 32'd0;
`endif

    // Randomized traffic checked against the queue model every cycle
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 31) == 0);
      pu = 2'($urandom_range(0, 3));
      po = 2'($urandom_range(0, 3));
      step(r, f, pu, po);
    end
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
